ldst_unit: RTL
==============

Name: ldst_unit

Overview:
Load/store initiator that drives the team's 64-bit doubleword memory (registered read data one cycle after enable, write on clock edge, doubleword address [63:3]). Accepts byte-addressed PowerPC loads and stores of 1/2/4/8 bytes from the execute stage. Extracts big-endian lanes for loads and performs read-modify-write for sub-doubleword stores. Handles one transaction at a time and uses memory read port 1 plus the write port.

Parameters:
none (data path fixed at 64 bits, doubleword addressing fixed at [63:3])

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  asynchronous, active-high reset
reqValid  input  1  request present
reqReady  output  1  unit can accept; =(state==IDLE) && !reset
reqWe  input  1  1=store, 0=load
reqAddr  input  64  byte address
reqSize  input  2  0=byte 1=half 2=word 3=dword
reqWData  input  64  store data, right-justified (low bits)
respValid  output  1  one-cycle completion pulse, no backpressure
respData  output  64  load result, zero-extended, right-justified; 0 for stores/errors
respErr  output  1  misaligned request (valid with respValid)
memReadEn  output  1  to memory readEn1
memReadAddr  output  61 [63:3]  to memory readAddr1
memReadData  input  64  from memory readData1
memWriteEn  output  1  to memory writeEn
memWriteAddr  output  61 [63:3]  to memory writeAddr
memWriteData  output  64  to memory writeData

Behaviour:
- Fire = reqValid && reqReady. Cycle 0 = fire cycle. Request fields latched on fire.
- Big-endian lanes: byte offset k=reqAddr[2:0] occupies bits [63-8k -: 8]. Lane width = 8<<reqSize bits.
- memReadEn is combinational: fire && !misaligned && (load || reqSize!=3). memReadAddr = reqAddr[63:3] while IDLE; all other memory outputs are registered.
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- Load: cycle 0 read issued, IDLE->LOAD. Cycle 1: extract the lane from memReadData, zero-extend into respData reg, ->RESP. Cycle 2: respValid=1, ->IDLE. Latency 2.
- Dword store: cycle 0 latch, ->WRITE. Cycle 1: memWriteEn=1, memWriteAddr=addr[63:3], memWriteData=reqWData, respValid=1, ->IDLE. Latency 1.
- Sub-dword store: cycle 0 read issued, ->MERGE. Cycle 1: memReadData is used with only the target lane replaced by reqWData low bits, then registered, ->WRITE. Cycle 2: memWriteEn=1, respValid=1, ->IDLE. Latency 2.
- Misaligned (addr & ((1<<size)-1) != 0, macro on): no memory access, ->RESP. Cycle 1: respValid=1, respErr=1, respData=0.
- memWriteEn is high for exactly one cycle per store and low otherwise. respValid is high exactly one cycle per accepted request.
- reqReady is low in every non-IDLE state. The unit ignores requests until IDLE. Back-to-back requests are accepted on the cycle after respValid drops, i.e. in the first IDLE cycle.
- Reset values: state=IDLE, respValid=0, respData=0, respErr=0, memWriteEn=0, memWriteAddr=0, memWriteData=0.
- Reset mid-operation aborts immediately. A pending store (MERGE or WRITE) is not written, and no respValid is issued for the aborted request.

Optional Feature:
LDST_ALIGN_CHECK_EN
- Defined: misaligned requests complete with respErr=1 as above.
- Undefined: respErr is tied to 0. Low address bits below natural alignment are masked (addr & ~((1<<size)-1)), and the request proceeds as the aligned access.

Test Plan:
- Reset asserted mid-idle then released -> reqReady=1, respValid=0, memWriteEn=0, respData=0.
- Dword store 0x0123456789ABCDEF @0x40 -> cycle1 memWriteEn=1, memWriteAddr=0x8, data as given, respValid=1. Then dword load @0x40 -> cycle2 respValid=1, respData=0x0123456789ABCDEF.
- With doubleword @0x40 = 0x0123456789ABCDEF: byte load @0x43 -> 0x67; half @0x46 -> 0xCDEF; word @0x44 -> 0x89ABCDEF; each respValid at cycle 2.
- Byte store 0xAA @0x41 -> memReadEn cycle0; cycle2 single memWriteEn with memWriteData=0x01AA456789ABCDEF; reload dword confirms.
- Word load @0x42: macro on -> cycle1 respValid=1, respErr=1, no memReadEn/memWriteEn; macro off -> treated as @0x40, respData=0x01234567.
- reqValid held high across a byte store: reqReady low cycles 1-2, next fire in cycle 3. Reset during MERGE -> no memWriteEn, no respValid, memory unchanged.

Source files
------------

// File: rtl/ldst_unit.sv
// Big-endian load/store initiator for the 64-bit doubleword memory.
// Optional feature macro: LDST_ALIGN_CHECK_EN (fault misaligned requests instead of masking).
module ldst_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWe,
  input  logic [63:0] reqAddr,
  input  logic [1:0]  reqSize,
  input  logic [63:0] reqWData,
  output logic        respValid,
  output logic [63:0] respData,
  output logic        respErr,
  output logic        memReadEn,
  output logic [60:0] memReadAddr,
  input  logic [63:0] memReadData,
  output logic        memWriteEn,
  output logic [60:0] memWriteAddr,
  output logic [63:0] memWriteData
);

  typedef enum logic [2:0] {StIdle, StLoad, StMerge, StWrite, StResp} state_e;

  state_e      state;
  logic [60:0] addr_q;
  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic [63:0] wdata_q;

  logic        fire;
  logic        misaligned;
  logic [2:0]  align_mask;
  logic [63:0] eff_addr;
  logic [63:0] width_mask;
  logic [6:0]  lane_shift;
  logic [63:0] lane_mask;
  logic [63:0] load_lane;
  logic [63:0] merged;

  always_comb begin
    align_mask = 3'b000;
    unique case (reqSize)
      2'd0: align_mask = 3'b000;
      2'd1: align_mask = 3'b001;
      2'd2: align_mask = 3'b011;
      2'd3: align_mask = 3'b111;
    endcase
  end

`ifdef LDST_ALIGN_CHECK_EN
  assign misaligned = |(reqAddr[2:0] & align_mask);
  assign eff_addr   = reqAddr;
`else
  assign misaligned = 1'b0;
  assign eff_addr   = {reqAddr[63:3], reqAddr[2:0] & ~align_mask};
`endif

  assign reqReady    = (state == StIdle) && !reset;
  assign fire        = reqValid && reqReady;
  assign memReadEn   = fire && !misaligned && (!reqWe || reqSize != 2'd3);
  assign memReadAddr = (state == StIdle) ? eff_addr[63:3] : addr_q;

  always_comb begin
    width_mask = '1;
    unique case (size_q)
      2'd0: width_mask = 64'h0000_0000_0000_00ff;
      2'd1: width_mask = 64'h0000_0000_0000_ffff;
      2'd2: width_mask = 64'h0000_0000_ffff_ffff;
      2'd3: width_mask = 64'hffff_ffff_ffff_ffff;
    endcase
  end

  // Byte k sits at bits [63-8k -: 8]; shift brings the lane's LSB down to bit 0.
  assign lane_shift = 7'd64 - 7'({off_q, 3'b000}) - (7'd8 << size_q);
  assign lane_mask  = width_mask << lane_shift;
  assign load_lane  = (memReadData >> lane_shift) & width_mask;
  assign merged     = (memReadData & ~lane_mask) | ((wdata_q & width_mask) << lane_shift);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      addr_q       <= '0;
      off_q        <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      respValid    <= 1'b0;
      respData     <= '0;
      respErr      <= 1'b0;
      memWriteEn   <= 1'b0;
      memWriteAddr <= '0;
      memWriteData <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (fire) begin
            addr_q  <= eff_addr[63:3];
            off_q   <= eff_addr[2:0];
            size_q  <= reqSize;
            wdata_q <= reqWData;
            if (misaligned) begin
              respValid <= 1'b1;
              respErr   <= 1'b1;
              respData  <= '0;
              state     <= StResp;
            end else if (!reqWe) begin
              state <= StLoad;
            end else if (reqSize == 2'd3) begin
              memWriteEn   <= 1'b1;
              memWriteAddr <= eff_addr[63:3];
              memWriteData <= reqWData;
              respValid    <= 1'b1;
              state        <= StWrite;
            end else begin
              state <= StMerge;
            end
          end
        end
        StLoad: begin
          respData  <= load_lane;
          respValid <= 1'b1;
          state     <= StResp;
        end
        StMerge: begin
          memWriteEn   <= 1'b1;
          memWriteAddr <= addr_q;
          memWriteData <= merged;
          respValid    <= 1'b1;
          state        <= StWrite;
        end
        StWrite: begin
          memWriteEn <= 1'b0;
          respValid  <= 1'b0;
          state      <= StIdle;
        end
        StResp: begin
          respValid <= 1'b0;
          respErr   <= 1'b0;
          respData  <= '0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
